mem_stage_sram_ctrl: RTL and testbench

//  MEM-stage memory controller directly downstream of the EXE-stage ALU. Takes the
//  ALU result as byte address plus the store value; runs a multi-cycle access to an

---
 rtl/mem_stage_sram_ctrl.sv | 118 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Purpose:      MEM-stage controller that turns the ALU byte address and store value
//               into a multi-cycle access to an external single-port SRAM.
// Latency:      a request first seen in IDLE at cycle T completes (ready=1) at T+WAIT_CYCLES+1.
// Backpressure: ready drops in the same cycle a request appears and stays low until DONE;
//               the pipeline freeze logic stalls every stage on ready=0.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mem_r_en / mem_w_en   load / store request, held by the pipeline until ready=1
//   alu_res, st_val       byte address and store data from the EXE stage
//   rd_data               load result, valid in the ready=1 cycle of a load
//   ready                 0 = busy, freeze the pipeline
//   sram_*                word address, write data, read data and active-low strobes
module mem_stage_sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [DATA_W-1:0]      alu_res,
    input  logic [DATA_W-1:0]      st_val,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic [DATA_W-1:0]      sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    // Counter only has to reach WAIT_CYCLES-1; it is cleared on the final access cycle.
    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic             req;

    assign req = mem_r_en | mem_w_en;

    // ready must fall in the very cycle a request shows up in IDLE, so it is
    // decoded from the current state and the live request rather than registered.
    always_comb begin
        ready = 1'b0;
        unique case (state)
            IDLE:    ready = ~req;
            ACCESS:  ready = 1'b0;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_load    <= 1'b0;
            rd_data    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        // Byte address relative to the SRAM window, converted to a
                        // word index. Below-base addresses wrap modulo 2^DATA_W and the
                        // byte offset bits fall off in the shift.
                        sram_addr  <= SRAM_ADDR_W'((alu_res - DATA_W'(BASE_ADDR)) >> 2);
                        sram_wdata <= st_val;
                        // Both enables high is treated as a store.
                        is_load    <= ~mem_w_en;
                        sram_we_n  <= ~mem_w_en;
                        sram_oe_n  <= mem_w_en;
                        cnt        <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        if (is_load) begin
                            rd_data <= sram_rdata;
                        end
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // The request is still asserted here because the pipeline only
                    // advances on this edge; it must not start a second access.
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int BASE = 1024;
    localparam int W    = 5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          mem_r_en = 1'b0;
    logic          mem_w_en = 1'b0;
    logic [DW-1:0] alu_res  = '0;
    logic [DW-1:0] st_val   = '0;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_we_n;
    logic          sram_oe_n;

    int nvec = 0;
    int nmis = 0;

    // External SRAM: pre-filled with a known pattern on the first edge.
    logic [DW-1:0] sram_mem [0:65535];
    bit            filled = 1'b0;

    // Reference model: word-indexed memory plus last load result.
    bit [DW-1:0] ref_mem [int];
    bit [DW-1:0] ref_rd = '0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .DATA_W(DW), .SRAM_ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .st_val(st_val), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h0BADF00D;
    endfunction

    assign sram_rdata = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 65536; i++) sram_mem[i] <= pat(i);
            filled <= 1'b1;
        end else if (sram_we_n === 1'b0) begin
            sram_mem[sram_addr] <= sram_wdata;
        end
    end

    function automatic bit [DW-1:0] ref_read(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : pat(idx);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request through the handshake: drive after an edge, hold the enables
    // until ready=1, scramble address/data once the request has been taken.
    task automatic do_access(input bit rd, input bit wr, input logic [DW-1:0] a,
                             input logic [DW-1:0] d, input string tag);
        int            lat;
        int            wec;
        int            oec;
        int            idx;
        bit            seen;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] got_addr;
        logic [DW-1:0] got_wd;
        exp_addr = AW'((a - 32'(BASE)) >> 2);
        idx      = int'(exp_addr);
        @(posedge clk); #1;
        mem_r_en = rd; mem_w_en = wr; alu_res = a; st_val = d;
        lat = 0; wec = 0; oec = 0; seen = 1'b0; got_addr = 'x; got_wd = 'x;
        @(negedge clk);
        while (ready !== 1'b1 && lat < 40) begin
            lat++;
            if (sram_we_n === 1'b0) wec++;
            if (sram_oe_n === 1'b0) oec++;
            if (!seen && (sram_we_n === 1'b0 || sram_oe_n === 1'b0)) begin
                seen = 1'b1; got_addr = sram_addr; got_wd = sram_wdata;
            end
            if (lat >= 2) begin
                alu_res = $urandom; st_val = $urandom;
            end
            @(negedge clk);
        end
        if (wr) ref_mem[idx] = d;
        else    ref_rd = ref_read(idx);
        check({tag, "/latency"}, 32'(lat), 32'(W + 1));
        check({tag, "/we_cycles"}, 32'(wec), wr ? 32'(W) : 32'd0);
        check({tag, "/oe_cycles"}, 32'(oec), wr ? 32'd0 : 32'(W));
        check({tag, "/sram_addr"}, 32'(got_addr), 32'(exp_addr));
        if (wr) check({tag, "/sram_wdata"}, got_wd, d);
        check({tag, "/rd_data"}, rd_data, ref_rd);
        check({tag, "/done_strobes"}, {30'd0, sram_we_n, sram_oe_n}, 32'd3);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle/ready", 32'(ready), 32'd1);
            check("idle/strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        end
    endtask

    initial begin
        int         k;
        int         gap;
        bit         rd;
        bit         wr;
        logic [DW-1:0] a;

        // 1. reset, then ten quiet cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst/sram_addr", 32'(sram_addr), 32'd0);
        check("rst/sram_wdata", sram_wdata, 32'd0);
        repeat (10) begin
            check("rst/ready", 32'(ready), 32'd1);
            check("rst/strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
            check("rst/rd_data", rd_data, 32'd0);
            @(negedge clk);
        end

        // 2/3. store then load the same word
        do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "t2_store");
        idle(1);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, "t3_load");
        check("t3/rd_value", rd_data, 32'hDEADBEEF);

        // 4. address mapping, back-to-back loads
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, "t4_1024");
        do_access(1'b1, 1'b0, 32'd1031, 32'h0, "t4_1031");
        do_access(1'b1, 1'b0, 32'd1020, 32'h0, "t4_1020");
        check("t4/wrap_value", rd_data, pat(16'hFFFF));

        // 5. reset during the third access cycle of a load
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1036;
        repeat (4) @(negedge clk);
        check("t5/in_access_oe", 32'(sram_oe_n), 32'd0);
        rst = 1'b1; mem_r_en = 1'b0;
        @(negedge clk);
        ref_rd = '0;
        check("t5/ready", 32'(ready), 32'd1);
        check("t5/strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("t5/rd_data", rd_data, 32'd0);
        rst = 1'b0;
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, "t5_load");

        // 6. load, store, then both enables high (acts as a store)
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, "t6_load");
        do_access(1'b0, 1'b1, 32'd1044, 32'hCAFEF00D, "t6_store");
        do_access(1'b1, 1'b1, 32'd1048, 32'h12345678, "t6_both");
        idle(1);
        do_access(1'b1, 1'b0, 32'd1048, 32'h0, "t6_readback");

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            rd = (k < 5) || (k == 9);
            wr = (k >= 5);
            a  = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                a = 32'(BASE) - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            do_access(rd, wr, a, $urandom, "rand");
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
